// File: rtl/snd_psg_bridge_pkg.sv
// snd_psg_bridge_pkg: dispatcher state encoding, hold length and pointer-width helper
package snd_psg_bridge_pkg;
  typedef enum logic [1:0] {IDLE, STROBE, HOLD, WAIT} disp_state_t;
  localparam int HOLD_CYCLES = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/snd_psg_bridge_if.sv
// snd_psg_bridge_if: CPU bus, PSG handshake/audio, mixer and status signals; master = host side, slave = bridge
interface snd_psg_bridge_if #(parameter int NCHIP = 2);
  logic [15:0]        CPUAD;
  logic               CPUMX;
  logic               CPUWR;
  logic [7:0]         CPUWD;
  logic               pause;
  logic [NCHIP-1:0]   psg_ready;
  logic [NCHIP*8-1:0] psg_out;
  logic [NCHIP-1:0]   psg_we;
  logic [7:0]         psg_data;
  logic               snd_ce;
  logic [NCHIP-1:0]   fifo_ovf;
  logic [7:0]         SNDOUT;
  modport master (output CPUAD, CPUMX, CPUWR, CPUWD, pause, psg_ready, psg_out,
                  input psg_we, psg_data, snd_ce, fifo_ovf, SNDOUT);
  modport slave (input CPUAD, CPUMX, CPUWR, CPUWD, pause, psg_ready, psg_out,
                 output psg_we, psg_data, snd_ce, fifo_ovf, SNDOUT);
endinterface

// File: rtl/snd_psg_bridge_frac_ce.sv
// snd_frac_ce: fractional clock enable, CE_NUM pulses per CE_DEN cycles; ports CPUCL, reset (async high), ce (registered pulse)
module snd_frac_ce #(
  parameter int CE_NUM = 8,
  parameter int CE_DEN = 117,
  parameter int ACC_W  = 8
) (
  input  logic CPUCL,
  input  logic reset,
  output logic ce
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             wrap;
  assign sum  = {1'b0, acc} + (ACC_W+1)'(CE_NUM);
  assign wrap = sum >= (ACC_W+1)'(CE_DEN);
  always_ff @(posedge CPUCL or posedge reset)
    if (reset) begin
      acc <= '0;
      ce  <= 1'b0;
    end else begin
      acc <= wrap ? ACC_W'(sum - (ACC_W+1)'(CE_DEN)) : sum[ACC_W-1:0];
      ce  <= wrap;
    end
endmodule

// File: rtl/snd_psg_bridge.sv
// snd_psg_bridge: CPU latch + per-chip FIFOs + READY-aware PSG dispatcher + clock enable + saturating mixer; ports CPUCL, reset (async high), b (slave bus)
module snd_psg_bridge
  import snd_psg_bridge_pkg::*;
#(
  parameter int         NCHIP        = 2,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] LATCH_PAGE   = 8'hF2,
  parameter logic [7:0] WR_PAGE_BASE = 8'hF4,
  parameter int         CE_NUM       = 8,
  parameter int         CE_DEN       = 117,
  parameter int         ACC_W        = 8
) (
  input logic CPUCL,
  input logic reset,
  snd_psg_bridge_if.slave b
);
  localparam int CW = NCHIP > 1 ? clog2(NCHIP) : 1;
  localparam int PW = clog2(FIFO_DEPTH);
  logic [7:0]       sndlatch;
  logic             sel_lc, sel_lc_q;
  logic [NCHIP-1:0] sel_wr, sel_wr_q, wr_rise, nonempty;
  logic [7:0]       head [NCHIP];
  disp_state_t      state, state_n;
  logic [CW-1:0]    cur, cur_n, rr, rr_n, pick;
  logic [1:0]       hcnt, hcnt_n;
  logic [7:0]       data_n;
  logic             found;
  int               j;
  logic [9:0]       mix;
  snd_frac_ce #(.CE_NUM(CE_NUM), .CE_DEN(CE_DEN), .ACC_W(ACC_W)) u_ce (
    .CPUCL(CPUCL),
    .reset(reset),
    .ce(b.snd_ce)
  );
  assign sel_lc  = b.CPUMX && b.CPUWR && b.CPUAD[15:8] == LATCH_PAGE;
  assign wr_rise = sel_wr & ~sel_wr_q;
  always_comb begin
    sel_wr = '0;
    for (int i = 0; i < NCHIP; i++) sel_wr[i] = b.CPUMX && b.CPUAD[15:8] == WR_PAGE_BASE + 8'(i);
  end
  always_comb begin
    mix = '0;
    for (int i = 0; i < NCHIP; i++) mix = mix + 10'(b.psg_out[8*i +: 8]);
  end
  for (genvar k = 0; k < NCHIP; k++) begin : g_fifo
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic          pop, put, ovf;
    assign pop = state == STROBE && cur == CW'(k);
    // a full FIFO still accepts a push in the cycle it is being popped
    assign put = wr_rise[k] && (cnt != (PW+1)'(FIFO_DEPTH) || pop);
    assign nonempty[k]   = cnt != '0;
    assign head[k]       = mem[rp];
    assign b.fifo_ovf[k] = ovf;
    always_ff @(posedge CPUCL)
      if (put) mem[wp] <= sndlatch;
    always_ff @(posedge CPUCL or posedge reset)
      if (reset) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        wp  <= put ? wp + 1'b1 : wp;
        rp  <= pop ? rp + 1'b1 : rp;
        cnt <= cnt + (PW+1)'(put) - (PW+1)'(pop);
        ovf <= ovf || (wr_rise[k] && !put);
      end
  end
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int i = 0; i < NCHIP; i++) begin
      j = (int'(rr) + i) % NCHIP;
      if (!found && nonempty[j] && b.psg_ready[j]) begin
        found = 1'b1;
        pick  = CW'(j);
      end
    end
  end
  always_comb begin
    state_n = state;
    cur_n   = cur;
    rr_n    = rr;
    hcnt_n  = hcnt;
    data_n  = b.psg_data;
    case (state)
      IDLE: begin
        state_n = found ? STROBE : IDLE;
        cur_n   = found ? pick : cur;
        data_n  = found ? head[pick] : b.psg_data;
      end
      STROBE: begin
        state_n = HOLD;
        hcnt_n  = '0;
        rr_n    = (cur == CW'(NCHIP-1)) ? '0 : cur + 1'b1;
      end
      HOLD: begin
        state_n = (hcnt == 2'(HOLD_CYCLES-1)) ? WAIT : HOLD;
        hcnt_n  = hcnt + 1'b1;
      end
      WAIT: state_n = b.psg_ready[cur] ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  assign b.psg_we = (state == STROBE) ? NCHIP'(1) << cur : '0;
  always_ff @(posedge CPUCL or posedge reset)
    if (reset) begin
      sel_lc_q   <= 1'b0;
      sel_wr_q   <= '0;
      sndlatch   <= '0;
      b.SNDOUT   <= '0;
      b.psg_data <= '0;
      state      <= IDLE;
      cur        <= '0;
      rr         <= '0;
      hcnt       <= '0;
    end else begin
      sel_lc_q   <= sel_lc;
      sel_wr_q   <= sel_wr;
      sndlatch   <= (sel_lc && !sel_lc_q) ? b.CPUWD : sndlatch;
      b.SNDOUT   <= b.pause ? 8'h00 : (mix > 10'd255 ? 8'hFF : mix[7:0]);
      b.psg_data <= data_n;
      state      <= state_n;
      cur        <= cur_n;
      rr         <= rr_n;
      hcnt       <= hcnt_n;
    end
endmodule

// File: tb/tb_snd_psg_bridge.sv
// tb_snd_psg_bridge: directed self-checking bench for snd_psg_bridge
module tb_snd_psg_bridge;
  typedef struct {int t; logic [1:0] we; logic [7:0] d;} strobe_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  strobe_t sq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  snd_psg_bridge_if #(.NCHIP(2)) bus();
  snd_psg_bridge #(.NCHIP(2)) dut (.CPUCL(clk), .reset(rst), .b(bus.slave));
  always @(negedge clk) if (bus.psg_we !== 2'b00) sq.push_back('{cyc, bus.psg_we, bus.psg_data});
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cpu(input logic [15:0] a, input logic [7:0] d, input int len);
    bus.CPUAD = a;
    bus.CPUMX = 1'b1;
    bus.CPUWR = 1'b1;
    bus.CPUWD = d;
    tick(len);
    bus.CPUMX = 1'b0;
    bus.CPUWR = 1'b0;
    tick(1);
  endtask
  task automatic push(input int k, input logic [7:0] d);
    cpu(16'hF200, d, 2);
    cpu(16'hF400 + 16'(k << 8), 8'h00, 2);
  endtask
  task automatic wait_sq(input int n, input int budget);
    int i;
    i = 0;
    while (sq.size() < n && i < budget) begin
      tick(1);
      i++;
    end
  endtask
  task automatic test_reset;
    bus.CPUAD = '0;
    bus.CPUMX = 1'b0;
    bus.CPUWR = 1'b0;
    bus.CPUWD = '0;
    bus.pause = 1'b0;
    bus.psg_ready = 2'b11;
    bus.psg_out = 16'hFFFF;
    tick(3);
    total++; if (bus.psg_we !== 2'b00) begin bad++; $display("FAIL reset_we got=%b want=00", bus.psg_we); end
    total++; if (bus.psg_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.psg_data); end
    total++; if (bus.snd_ce !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b want=0", bus.snd_ce); end
    total++; if (bus.fifo_ovf !== 2'b00) begin bad++; $display("FAIL reset_ovf got=%b want=00", bus.fifo_ovf); end
    total++; if (bus.SNDOUT !== 8'h00) begin bad++; $display("FAIL reset_sndout got=%h want=00", bus.SNDOUT); end
    bus.psg_out = 16'h0000;
    rst = 1'b0;
  endtask
  task automatic test_ce;
    int n, n1, adj, first;
    logic prev;
    n = 0; n1 = 0; adj = 0; first = -1; prev = 1'b0;
    for (int i = 1; i <= 234; i++) begin
      tick(1);
      if (bus.snd_ce === 1'b1) begin
        n++;
        if (first < 0) first = i;
        if (prev) adj++;
      end
      prev = bus.snd_ce;
      if (i == 117) n1 = n;
    end
    total++; if (first !== 15) begin bad++; $display("FAIL ce_first got=%0d want=15", first); end
    total++; if (n1 !== 8) begin bad++; $display("FAIL ce_window1 got=%0d want=8", n1); end
    total++; if (n !== 16) begin bad++; $display("FAIL ce_window2 got=%0d want=16", n); end
    total++; if (adj !== 0) begin bad++; $display("FAIL ce_adjacent got=%0d want=0", adj); end
  endtask
  task automatic test_latch_push;
    int t1;
    sq.delete();
    cpu(16'hF200, 8'h9F, 2);
    cpu(16'hF500, 8'h00, 20);
    tick(5);
    total++; if (sq.size() !== 1) begin bad++; $display("FAIL lp_count got=%0d want=1", sq.size()); end
    total++; if (sq[0].we !== 2'b10) begin bad++; $display("FAIL lp_we got=%b want=10", sq[0].we); end
    total++; if (sq[0].d !== 8'h9F) begin bad++; $display("FAIL lp_data got=%h want=9f", sq[0].d); end
    total++; if (bus.psg_data !== 8'h9F) begin bad++; $display("FAIL lp_hold got=%h want=9f", bus.psg_data); end
    bus.psg_ready = 2'b01;
    push(1, 8'hA5);
    tick(30);
    total++; if (sq.size() !== 1) begin bad++; $display("FAIL lp_busy got=%0d strobes want=1", sq.size()); end
    t1 = cyc;
    bus.psg_ready = 2'b11;
    wait_sq(2, 10);
    total++; if (sq.size() !== 2) begin bad++; $display("FAIL lp_resume got=%0d strobes want=2", sq.size()); end
    total++; if (sq[1].d !== 8'hA5 || sq[1].we !== 2'b10) begin bad++; $display("FAIL lp_second got=%b/%h want=10/a5", sq[1].we, sq[1].d); end
    total++; if (sq[1].t <= t1) begin bad++; $display("FAIL lp_after_ready got=%0d want>%0d", sq[1].t, t1); end
  endtask
  task automatic test_round_robin;
    logic [1:0] ew [3];
    logic [7:0] ed [3];
    ew = '{2'b01, 2'b10, 2'b01};
    ed = '{8'hA1, 8'hB1, 8'hA2};
    sq.delete();
    bus.psg_ready = 2'b00;
    push(0, 8'hA1);
    push(0, 8'hA2);
    push(1, 8'hB1);
    bus.psg_ready = 2'b11;
    wait_sq(3, 40);
    tick(10);
    total++; if (sq.size() !== 3) begin bad++; $display("FAIL rr_count got=%0d want=3", sq.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sq[i].we !== ew[i] || sq[i].d !== ed[i]) begin
        bad++; $display("FAIL rr_order[%0d] got=%b/%h want=%b/%h", i, sq[i].we, sq[i].d, ew[i], ed[i]);
      end
    end
  endtask
  task automatic test_overflow;
    logic [7:0] v [6];
    v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sq.delete();
    bus.psg_ready = 2'b00;
    for (int i = 0; i < 6; i++) push(0, v[i]);
    total++; if (bus.fifo_ovf !== 2'b01) begin bad++; $display("FAIL ovf_flag got=%b want=01", bus.fifo_ovf); end
    total++; if (sq.size() !== 0) begin bad++; $display("FAIL ovf_nostrobe got=%0d want=0", sq.size()); end
    bus.psg_ready = 2'b11;
    wait_sq(4, 60);
    tick(10);
    total++; if (sq.size() !== 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", sq.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sq[i].d !== v[i] || sq[i].we !== 2'b01) begin
        bad++; $display("FAIL ovf_data[%0d] got=%b/%h want=01/%h", i, sq[i].we, sq[i].d, v[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (sq[i].t - sq[i-1].t < 4) begin bad++; $display("FAIL ovf_gap[%0d] got=%0d want>=4", i, sq[i].t - sq[i-1].t); end
    end
    total++; if (bus.fifo_ovf !== 2'b01) begin bad++; $display("FAIL ovf_sticky got=%b want=01", bus.fifo_ovf); end
  endtask
  task automatic test_mixer;
    bus.psg_out = {8'h70, 8'hC0};
    tick(1);
    total++; if (bus.SNDOUT !== 8'hFF) begin bad++; $display("FAIL mix_sat got=%h want=ff", bus.SNDOUT); end
    bus.psg_out = {8'h80, 8'h80};
    tick(1);
    total++; if (bus.SNDOUT !== 8'hFF) begin bad++; $display("FAIL mix_256 got=%h want=ff", bus.SNDOUT); end
    bus.psg_out = {8'h7F, 8'h80};
    tick(1);
    total++; if (bus.SNDOUT !== 8'hFF) begin bad++; $display("FAIL mix_255 got=%h want=ff", bus.SNDOUT); end
    bus.psg_out = {8'h20, 8'h30};
    #2;
    total++; if (bus.SNDOUT !== 8'hFF) begin bad++; $display("FAIL mix_latency got=%h want=ff", bus.SNDOUT); end
    tick(1);
    total++; if (bus.SNDOUT !== 8'h50) begin bad++; $display("FAIL mix_sum got=%h want=50", bus.SNDOUT); end
    bus.pause = 1'b1;
    tick(1);
    total++; if (bus.SNDOUT !== 8'h00) begin bad++; $display("FAIL mix_pause got=%h want=00", bus.SNDOUT); end
    bus.pause = 1'b0;
    tick(1);
    total++; if (bus.SNDOUT !== 8'h50) begin bad++; $display("FAIL mix_unpause got=%h want=50", bus.SNDOUT); end
    bus.psg_out = 16'h0000;
    tick(1);
  endtask
  task automatic test_reset_mid_wait;
    int i;
    sq.delete();
    bus.psg_ready = 2'b00;
    push(0, 8'h77);
    push(0, 8'h88);
    bus.psg_ready = 2'b11;
    i = 0;
    while (bus.psg_we === 2'b00 && i < 20) begin
      tick(1);
      i++;
    end
    total++; if (bus.psg_we !== 2'b01) begin bad++; $display("FAIL rst_pre_strobe got=%b want=01", bus.psg_we); end
    bus.psg_ready = 2'b10;
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.fifo_ovf !== 2'b00) begin bad++; $display("FAIL rst_async_ovf got=%b want=00", bus.fifo_ovf); end
    total++; if (bus.psg_data !== 8'h00) begin bad++; $display("FAIL rst_async_data got=%h want=00", bus.psg_data); end
    tick(2);
    rst = 1'b0;
    bus.psg_ready = 2'b11;
    tick(20);
    total++; if (sq.size() !== 1) begin bad++; $display("FAIL rst_no_strobe got=%0d want=1", sq.size()); end
    total++; if (bus.fifo_ovf !== 2'b00) begin bad++; $display("FAIL rst_ovf_after got=%b want=00", bus.fifo_ovf); end
  endtask
  initial begin
    test_reset;
    test_ce;
    test_latch_push;
    test_round_robin;
    test_overflow;
    test_mixer;
    test_reset_mid_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snd_psg_bridge.md
Name: snd_psg_bridge

Overview:
- Parametrised successor to the single-chip sound front end.
- CPU-side command latch; per-chip write-select decode for NCHIP SN76496-class PSGs.
- Per-chip command FIFOs, plus a dispatcher that honours each PSG's READY handshake.
- Fractional clock-enable generator, plus a saturating output mixer with pause mute. PSG cores sit outside and are clocked by CPUCL gated with snd_ce.

Parameters:
- NCHIP, 2, number of PSG chips (1..4).
- FIFO_DEPTH, 4, entries per chip FIFO (power of 2, >=2).
- LATCH_PAGE, 8'hF2, CPUAD[15:8] value selecting the command latch.
- WR_PAGE_BASE, 8'hF4, CPUAD[15:8] for chip 0; chip k uses WR_PAGE_BASE+k.
- CE_NUM, 8, clock-enable numerator.
- CE_DEN, 117, clock-enable denominator (CE_NUM < CE_DEN required).
- ACC_W, 8, accumulator width (2^ACC_W > CE_DEN+CE_NUM required).

Ports:
- CPUCL  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- CPUAD  in  16  CPU address.
- CPUMX  in  1  CPU bus cycle qualifier.
- CPUWR  in  1  CPU write strobe (level, may span many cycles).
- CPUWD  in  8  CPU write data.
- pause  in  1  mute request.
- psg_ready  in  NCHIP  per-chip READY from the PSG (1 = idle).
- psg_out  in  NCHIP*8  per-chip unsigned audio, chip k in bits [8k+7:8k].
- psg_we  out  NCHIP  one-cycle write strobe to chip k.
- psg_data  out  8  shared write data bus.
- snd_ce  out  1  PSG clock enable, one-cycle pulses.
- fifo_ovf  out  NCHIP  sticky overflow flag per chip.
- SNDOUT  out  8  mixed audio.

Behaviour:
- Clock and reset: one clock, CPUCL; reset is asynchronous, active-high, and drives every register to its reset value immediately.
- Reset values: SNDLATCH=0, psg_we=0, psg_data=0, snd_ce=0, fifo_ovf=0, SNDOUT=0, all FIFOs empty, accumulator=0, dispatcher IDLE, round-robin pointer=0.
- Select decode:
  - sel_lc = (CPUAD[15:8]==LATCH_PAGE) & CPUMX & CPUWR.
  - sel_wr[k] = (CPUAD[15:8]==WR_PAGE_BASE+k) & CPUMX.
  - Each select is registered; the action fires only on its 0->1 transition, so one action per CPU access regardless of strobe length.
- Latch: on a sel_lc rise, SNDLATCH <= CPUWD (the value of CPUWD in the cycle the rise is detected).
- Push: on a sel_wr[k] rise, push SNDLATCH into FIFO k.
  - Same-cycle latch and push: the push takes the old SNDLATCH.
  - Push into a full FIFO: data is dropped and fifo_ovf[k] is set; it stays set until reset.
- Dispatcher FSM:
  - IDLE: select the lowest-index non-empty FIFO at or after the round-robin pointer whose psg_ready=1. If none, stay IDLE.
  - STROBE (1 cycle): psg_we[k]=1, psg_data=FIFO k head; pop FIFO k; pointer <= k+1 mod NCHIP.
  - HOLD (2 cycles): covers the PSG's READY deassert latency; psg_ready is ignored.
  - WAIT: remain until psg_ready[k]=1, then go to IDLE.
  - Minimum 4 cycles between strobes to the same chip.
  - psg_data holds its last value outside STROBE.
  - Simultaneous push and pop on one FIFO: both take effect and the count is unchanged. A push into a FIFO that is full in the same cycle it is popped is accepted.
  - pause does not stall the dispatcher.
- Clock enable (snd_frac_ce): every cycle, acc+CE_NUM is compared with CE_DEN.
  - If acc+CE_NUM >= CE_DEN: acc <= acc+CE_NUM-CE_DEN and snd_ce=1 (registered).
  - Otherwise: acc <= acc+CE_NUM and snd_ce=0.
  - Long-run rate is exactly CE_NUM/CE_DEN pulses per cycle; pulses are never adjacent.
- Mixer: SNDOUT registered, 1-cycle latency.
  - Zero-extended sum of all psg_out lanes, saturated to 8'hFF.
  - pause=1 forces SNDOUT=0 on the next cycle.

Decomposition:
- Shared package: dispatcher state encoding (IDLE, STROBE, HOLD, WAIT), HOLD_CYCLES=2, and a clog2 helper for FIFO pointer width.
- Sub-module snd_frac_ce: parameters CE_NUM, CE_DEN, ACC_W; ports CPUCL, reset, ce.
- FIFOs are inline arrays, generated per chip.

Test Plan:
- Reset held, then released with CE_NUM=8, CE_DEN=117 -> exactly 8 snd_ce pulses in 117 cycles (repeating), none adjacent; all outputs 0 during reset.
- Latch write 8'h9F, then a chip-1 select held 20 cycles -> one push; psg_we=2'b10 for one cycle with psg_data=8'h9F; psg_ready[1] low 30 cycles delays the next chip-1 strobe until ready returns.
- 6 chip-0 pushes (FIFO_DEPTH=4) with psg_ready[0]=0 -> 4 entries retained, fifo_ovf[0]=1; releasing ready delivers the 4 values in order at >=4-cycle spacing.
- Both FIFOs non-empty with both chips ready -> strobes alternate chip0, chip1, chip0 (round-robin).
- psg_out lanes 8'hC0 and 8'h70 -> SNDOUT=8'hFF; lanes 8'h30 and 8'h20 -> 8'h50 one cycle later; pause=1 -> 8'h00 on the next cycle.
- Reset asserted mid-WAIT with a non-empty FIFO -> immediate return to IDLE, FIFOs empty, fifo_ovf cleared, no strobe after release.
